// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window generator.
package conv_pkg;

  typedef logic signed [47:0] pixel_t;
  typedef logic [31:0]        coord_t;

  function automatic int halfk(input int k);
    return k / 2;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of pixel storage; the read returns the old entry at the
// shared address so the same slot can be overwritten in the same cycle.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int AW    = 10
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr,
  input  logic            wr_en,
  input  pixel_t          wr_data,
  output pixel_t          rd_data
);

  pixel_t mem_r [WIDTH];

  assign rd_data = mem_r[addr];

  // Storage write; contents are never reset because stale entries are never emitted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order KxK window generator: line buffers feed a shifting window
// register, and each interior pixel emits its window through one output stage.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int KERNEL_SIZE = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [47:0] in_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [47:0] out_window [KERNEL_SIZE][KERNEL_SIZE],
  output logic [31:0]        out_x,
  output logic [31:0]        out_y,
  output logic               out_last
);

  localparam int HK = halfk(KERNEL_SIZE);
  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  coord_t col_r;
  coord_t row_r;
  logic   accept_s;
  logic   emit_s;
  logic   out_valid_r;
  logic   out_last_r;
  coord_t out_x_r;
  coord_t out_y_r;
  pixel_t lb_rd_s   [KERNEL_SIZE-1];
  pixel_t lb_wr_s   [KERNEL_SIZE-1];
  pixel_t new_col_s [KERNEL_SIZE];
  pixel_t win_r     [KERNEL_SIZE][KERNEL_SIZE];

  assign in_ready = !out_valid_r | out_ready;
  assign accept_s = in_valid & in_ready;
  assign emit_s   = accept_s & (row_r >= coord_t'(KERNEL_SIZE-1))
                             & (col_r >= coord_t'(KERNEL_SIZE-1));

  // Line j receives what line j-1 held at this column: the image scrolls down one row.
  for (genvar j = 0; j < KERNEL_SIZE-1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign lb_wr_s[j] = in_pixel;
    end else begin : g_chain
      assign lb_wr_s[j] = lb_rd_s[j-1];
    end
    conv_line_buffer #(.WIDTH(WIDTH), .AW(AW)) u_lb (
      .clk     (clk),
      .addr    (col_r[AW-1:0]),
      .wr_en   (accept_s),
      .wr_data (lb_wr_s[j]),
      .rd_data (lb_rd_s[j])
    );
  end

  // New rightmost window column, oldest row on top.
  always_comb begin
    for (int r = 0; r < KERNEL_SIZE-1; r++) begin
      new_col_s[r] = lb_rd_s[KERNEL_SIZE-2-r];
    end
    new_col_s[KERNEL_SIZE-1] = in_pixel;
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_r <= '0;
      row_r <= '0;
    end else if (accept_s) begin
      if (col_r == coord_t'(WIDTH-1)) begin
        col_r <= '0;
        row_r <= (row_r == coord_t'(HEIGHT-1)) ? 32'd0 : row_r + 32'd1;
      end else begin
        col_r <= col_r + 32'd1;
      end
    end
  end

  // Window shifts left on every accept; it only changes when the output is free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          win_r[r][c] <= '0;
        end
      end
    end else if (accept_s) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE-1; c++) begin
          win_r[r][c] <= win_r[r][c+1];
        end
        win_r[r][KERNEL_SIZE-1] <= new_col_s[r];
      end
    end
  end

  // Output valid, centre coordinates and end-of-frame flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_x_r     <= '0;
      out_y_r     <= '0;
      out_last_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= emit_s;
      if (emit_s) begin
        out_x_r    <= col_r - coord_t'(HK);
        out_y_r    <= row_r - coord_t'(HK);
        out_last_r <= (col_r == coord_t'(WIDTH-1)) && (row_r == coord_t'(HEIGHT-1));
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_x      = out_x_r;
  assign out_y      = out_y_r;
  assign out_last   = out_last_r;
  assign out_window = win_r;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench: 5x5/K3 instance for frame, stall, sign, back-to-back and
// reset cases; 8x6/K5 instance under random handshakes.
module tb_conv_window_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic               in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1, out_last_a;
  logic signed [47:0] in_pixel_a = '0;
  logic signed [47:0] win_a [3][3];
  logic [31:0]        out_x_a, out_y_a;

  logic               in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1, out_last_b;
  logic signed [47:0] in_pixel_b = '0;
  logic signed [47:0] win_b [5][5];
  logic [31:0]        out_x_b, out_y_b;

  conv_window_gen #(.WIDTH(5), .HEIGHT(5), .KERNEL_SIZE(3)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_pixel(in_pixel_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_window(win_a), .out_x(out_x_a), .out_y(out_y_a), .out_last(out_last_a));

  conv_window_gen #(.WIDTH(8), .HEIGHT(6), .KERNEL_SIZE(5)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_pixel(in_pixel_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_window(win_b), .out_x(out_x_b), .out_y(out_y_b), .out_last(out_last_b));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint pixval(input int mode, input int f, input int r, input int c);
    longint b;
    b = longint'(f * 100 + 10 * r + c);
    if (mode == 1) return -b - 64'sd1;
    return b;
  endfunction

  // Scoreboard for instance A: window k of a run is frame k/9, centre (1+j%3, 1+j/3).
  int k_a = 0;
  int mode_a = 0;
  logic signed [47:0] fw00, lw00, lw22;
  logic [31:0] lx, ly;
  logic llast;
  always @(negedge clk) begin
    int j, f, ex, ey;
    if (out_valid_a && out_ready_a) begin
      j = k_a % 9; f = k_a / 9; ex = 1 + j % 3; ey = 1 + j / 3;
      check_eq("a_x", out_x_a, ex);
      check_eq("a_y", out_y_a, ey);
      check_eq("a_last", out_last_a, (j == 8) ? 1 : 0);
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          check_eq("a_win", win_a[r][c], pixval(mode_a, f, ey - 1 + r, ex - 1 + c));
      if (k_a == 0) fw00 = win_a[0][0];
      lw00 = win_a[0][0]; lw22 = win_a[2][2];
      lx = out_x_a; ly = out_y_a; llast = out_last_a;
      k_a++;
    end
  end

  // Scoreboard for instance B: window k is centred at (2+k%4, 2+k/4).
  int k_b = 0;
  always @(negedge clk) begin
    int ex, ey;
    if (out_valid_b && out_ready_b) begin
      ex = 2 + k_b % 4; ey = 2 + k_b / 4;
      check_eq("b_x", out_x_b, ex);
      check_eq("b_y", out_y_b, ey);
      check_eq("b_last", out_last_b, (k_b == 7) ? 1 : 0);
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          check_eq("b_win", win_b[r][c], longint'(10 * (ey - 2 + r) + (ex - 2 + c)));
      k_b++;
    end
  end

  // Present one pixel to A and return just after the edge that accepts it.
  task automatic push_a(input longint v);
    int guard;
    guard = 0;
    in_valid_a = 1'b1;
    in_pixel_a = 48'(v);
    @(negedge clk);
    while (!in_ready_a && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("a_push_timeout", in_ready_a, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame_a(input int mode, input int f, input bit first_chk, input bit stall);
    for (int i = 0; i < 25; i++) begin
      push_a(pixval(mode, f, i / 5, i % 5));
      if (first_chk && i == 11) check_eq("a_no_early_valid", out_valid_a, 0);
      if (first_chk && i == 12) begin
        check_eq("a_first_valid", out_valid_a, 1);
        check_eq("a_first_x", out_x_a, 1);
        check_eq("a_first_y", out_y_a, 1);
        check_eq("a_first_w00", win_a[0][0], 0);
        check_eq("a_first_w02", win_a[0][2], 2);
        check_eq("a_first_w10", win_a[1][0], 10);
        check_eq("a_first_w22", win_a[2][2], 22);
      end
      if (stall && i == 13) begin
        out_ready_a = 1'b0;
        in_pixel_a  = 48'(pixval(mode, f, 2, 4));
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          check_eq("stall_in_ready", in_ready_a, 0);
          check_eq("stall_valid", out_valid_a, 1);
          check_eq("stall_x", out_x_a, 2);
          check_eq("stall_y", out_y_a, 1);
          check_eq("stall_w00", win_a[0][0], 1);
          check_eq("stall_w11", win_a[1][1], 12);
          check_eq("stall_w22", win_a[2][2], 23);
        end
        @(posedge clk); #1;
        out_ready_a = 1'b1;
      end
    end
  endtask

  task automatic drain_a();
    in_valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, cyc;
    bit acc;
    // reset state
    @(negedge clk);
    check_eq("rst_valid", out_valid_a, 0);
    check_eq("rst_x", out_x_a, 0);
    check_eq("rst_y", out_y_a, 0);
    check_eq("rst_last", out_last_a, 0);
    check_eq("rst_w11", win_a[1][1], 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", in_ready_a, 1);
    @(posedge clk); #1;

    // basic frame
    mode_a = 0; k_a = 0;
    send_frame_a(0, 0, 1'b1, 1'b0);
    drain_a();
    check_eq("t1_windows", k_a, 9);
    check_eq("t1_last_w00", lw00, 22);
    check_eq("t1_last_w22", lw22, 44);
    check_eq("t1_last_x", lx, 3);
    check_eq("t1_last_y", ly, 3);
    check_eq("t1_last_flag", llast, 1);
    check_eq("t1_idle_valid", out_valid_a, 0);

    // backpressure
    k_a = 0;
    send_frame_a(0, 0, 1'b0, 1'b1);
    drain_a();
    check_eq("t2_windows", k_a, 9);

    // negative data
    mode_a = 1; k_a = 0;
    send_frame_a(1, 0, 1'b0, 1'b0);
    drain_a();
    check_eq("t3_windows", k_a, 9);
    check_eq("t3_first_w00", fw00, -1);

    // back-to-back frames, no gap
    mode_a = 0; k_a = 0;
    send_frame_a(0, 0, 1'b0, 1'b0);
    send_frame_a(0, 1, 1'b0, 1'b0);
    drain_a();
    check_eq("t4_windows", k_a, 18);

    // reset mid-frame
    for (int i = 0; i < 13; i++) push_a(pixval(0, 0, i / 5, i % 5));
    in_valid_a = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_valid", out_valid_a, 0);
    check_eq("t5_rst_x", out_x_a, 0);
    check_eq("t5_rst_y", out_y_a, 0);
    check_eq("t5_rst_w22", win_a[2][2], 0);
    @(posedge clk); #1;
    reset = 1'b1;
    k_a = 0;
    send_frame_a(0, 0, 1'b0, 1'b0);
    drain_a();
    check_eq("t5_windows", k_a, 9);

    // random handshakes on the 8x6 / K=5 instance
    idx = 0; acc = 1'b0; cyc = 0;
    while ((idx < 48 || k_b < 8) && cyc < 3000) begin
      @(posedge clk); #1;
      if (acc) idx++;
      in_valid_b  = (idx < 48) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_pixel_b  = 48'(10 * (idx / 8) + idx % 8);
      out_ready_b = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid_b && in_ready_b;
      cyc++;
    end
    in_valid_b = 1'b0;
    out_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    check_eq("t6_windows", k_b, 8);
    check_eq("t6_pixels", idx, 48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
